msg_slice_sequencer: RTL and testbench

Sequencing controller for the encoder input slicer. It accepts one K-bit message per valid/ready handshake, registers it, and then drives the `Data_MUX` select lines (`sm`, `sel`) to present the message to the encoder as DIV consecutive M*La-bit chunks. Each chunk is held until the encoder accepts it. The block sits between the SPI message assembler and the `Data_MUX` → encoder path, and produces a one-cycle completion pulse per message.

---
 rtl/rce_pkg.sv | 26 ++
 rtl/msg_slice_sequencer.sv | 119 +++++++++++
 tb/tb_msg_slice_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rce_pkg.sv
// Shared constants and state encoding for the encoder input slicer.
package rce_pkg;

  localparam int unsigned K       = 1024;
  localparam int unsigned M       = 32;
  localparam int unsigned La      = 8;
  localparam int unsigned CHUNK_W = M * La;
  localparam int unsigned DIV     = K / CHUNK_W;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SEL_W   = 2;

  // Chunk index of the final slice of a message.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Data_MUX select for a given chunk index; slices are selected in reverse.
  function automatic logic [SEL_W-1:0] sel_of(input logic [CNT_W-1:0] idx);
    return SEL_W'(~idx);
  endfunction

endpackage

// File: rtl/msg_slice_sequencer.sv
// Accepts one K-bit message per handshake and steps the Data_MUX select lines
// through DIV chunks, holding each until the encoder accepts it.
module msg_slice_sequencer
  import rce_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [K-1:0]     msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic [K-1:0]     msg_hold,
  output logic             sm,
  output logic [SEL_W-1:0] sel,
  output logic             chunk_valid,
  output logic [CNT_W-1:0] chunk_idx,
  output logic             chunk_last,
  input  logic             enc_ready,
  input  logic             flush,
  output logic             done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [K-1:0]       hold_q, hold_d;
  logic               sm_q, sm_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      sm_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sm_q    <= sm_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state and register updates; flush aborts to IDLE but keeps msg_hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    sm_d    = sm_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          hold_d  = msg_in;
          cnt_d   = '0;
          sm_d    = 1'b1;
          sel_d   = sel_of('0);
          state_d = SEND;
        end
      end
      SEND: begin
        if (flush) begin
          cnt_d   = '0;
          sm_d    = 1'b0;
          sel_d   = '0;
          state_d = IDLE;
        end else if (enc_ready) begin
          if (cnt_q == LAST_IDX) begin
            sm_d    = 1'b0;
            sel_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sel_d = sel_of(cnt_q + CNT_W'(1));
          end
        end
      end
      DONE: begin
        if (flush) begin
          cnt_d = '0;
          sm_d  = 1'b0;
          sel_d = '0;
        end
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        sm_d    = 1'b0;
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and chunk status decoded from the current state.
  always_comb begin
    msg_ready   = 1'b0;
    chunk_valid = 1'b0;
    chunk_idx   = '0;
    chunk_last  = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: msg_ready = 1'b1;
      SEND: begin
        chunk_valid = 1'b1;
        chunk_idx   = cnt_q;
        chunk_last  = (cnt_q == LAST_IDX);
      end
      DONE: done = 1'b1;
      default: msg_ready = 1'b0;
    endcase
  end

  assign msg_hold = hold_q;
  assign sm       = sm_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_msg_slice_sequencer.sv
// Self-checking bench for msg_slice_sequencer: directed scenarios plus a
// randomized run against a message/chunk-level reference model.
module tb_msg_slice_sequencer;

  localparam int unsigned TK  = 1024;
  localparam int unsigned TCW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [TK-1:0]   msg_in;
  logic            msg_valid;
  logic            msg_ready;
  logic [TK-1:0]   msg_hold;
  logic            sm;
  logic [1:0]      sel;
  logic            chunk_valid;
  logic [1:0]      chunk_idx;
  logic            chunk_last;
  logic            enc_ready;
  logic            flush;
  logic            done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msg_slice_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .msg_in     (msg_in),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_hold   (msg_hold),
    .sm         (sm),
    .sel        (sel),
    .chunk_valid(chunk_valid),
    .chunk_idx  (chunk_idx),
    .chunk_last (chunk_last),
    .enc_ready  (enc_ready),
    .flush      (flush),
    .done       (done)
  );

  // Data_MUX behaviour: sel 3 picks bits [255:0], sel 0 picks [1023:768].
  function automatic logic [TCW-1:0] mux_out(input logic [TK-1:0] m, input logic [1:0] s);
    int idx;
    idx = 3 - int'(s);
    return m[idx*TCW +: TCW];
  endfunction

  function automatic logic [TK-1:0] tagged_msg();
    logic [TK-1:0] m;
    for (int i = 0; i < 4; i++) m[i*TCW +: TCW] = TCW'(i + 1);
    return m;
  endfunction

  function automatic logic [TK-1:0] rand_msg();
    logic [TK-1:0] m;
    for (int i = 0; i < 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; msg_valid = 1'b0; enc_ready = 1'b0; flush = 1'b0; msg_in = rand_msg();
    tick(); tick();
    rst = 1'b0;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_msg_ready got=%b exp=1", msg_ready); end
    checks++; if (sm !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL reset_sm_sel got sm=%b sel=%0d exp 0/0", sm, sel); end
    checks++; if (chunk_valid !== 1'b0 || chunk_idx !== 2'd0 || chunk_last !== 1'b0) begin
      errors++; $display("FAIL reset_chunk got v=%b idx=%0d last=%b exp 0/0/0", chunk_valid, chunk_idx, chunk_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (msg_hold !== '0) begin errors++; $display("FAIL reset_msg_hold not zero"); end
  endtask

  task automatic test_basic();
    logic [TK-1:0] m;
    m = tagged_msg();
    msg_in = m; msg_valid = 1'b1; enc_ready = 1'b1;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", msg_ready); end
    tick();
    msg_valid = 1'b0; msg_in = rand_msg();
    for (int i = 0; i < 4; i++) begin
      checks++; if (chunk_valid !== 1'b1 || sm !== 1'b1 || msg_ready !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL basic_status c%0d got v=%b sm=%b rdy=%b done=%b exp 1/1/0/0", i, chunk_valid, sm, msg_ready, done); end
      checks++; if (sel !== 2'(3 - i) || chunk_idx !== 2'(i)) begin
        errors++; $display("FAIL basic_sel c%0d got sel=%0d idx=%0d exp sel=%0d idx=%0d", i, sel, chunk_idx, 3 - i, i); end
      checks++; if (mux_out(msg_hold, sel) !== TCW'(i + 1)) begin
        errors++; $display("FAIL basic_tag c%0d got=%0h exp=%0d", i, mux_out(msg_hold, sel), i + 1); end
      checks++; if (chunk_last !== (i == 3)) begin
        errors++; $display("FAIL basic_last c%0d got=%b exp=%b", i, chunk_last, (i == 3)); end
      tick();
    end
    checks++; if (done !== 1'b1 || chunk_valid !== 1'b0 || sm !== 1'b0 || msg_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%b v=%b sm=%b rdy=%b exp 1/0/0/0", done, chunk_valid, sm, msg_ready); end
    tick();
    checks++; if (done !== 1'b0 || msg_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_done got done=%b rdy=%b exp 0/1", done, msg_ready); end
    enc_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int stall, n, sel2, done_cyc;
    msg_in = tagged_msg(); msg_valid = 1'b1; enc_ready = 1'b1;
    tick();
    msg_valid = 1'b0;
    stall = 0; n = 0; sel2 = 0; done_cyc = -1;
    for (int cyc = 1; cyc < 20 && done_cyc < 0; cyc++) begin
      if (chunk_valid && chunk_idx == 2'd1 && stall < 3) begin enc_ready = 1'b0; stall++; end
      else enc_ready = 1'b1;
      if (chunk_valid && sel == 2'd2) begin
        sel2++;
        checks++; if (chunk_idx !== 2'd1) begin errors++; $display("FAIL bp_idx cyc=%0d got=%0d exp=1", cyc, chunk_idx); end
      end
      if (chunk_valid && enc_ready) begin
        checks++; if (mux_out(msg_hold, sel) !== TCW'(n + 1)) begin
          errors++; $display("FAIL bp_tag n=%0d got=%0h exp=%0d", n, mux_out(msg_hold, sel), n + 1); end
        n++;
      end
      if (done) done_cyc = cyc;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_chunks got=%0d exp=4", n); end
    checks++; if (sel2 !== 4) begin errors++; $display("FAIL bp_sel2_cycles got=%0d exp=4", sel2); end
    checks++; if (done_cyc !== 8) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=8", done_cyc); end
    enc_ready = 1'b0;
  endtask

  task automatic test_valid_during_send();
    logic [TK-1:0] a, b;
    bit seen;
    a = rand_msg(); b = rand_msg();
    msg_in = a; msg_valid = 1'b1; enc_ready = 1'b1;
    tick();
    msg_in = b;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      checks++; if (msg_ready !== 1'b0 || msg_hold !== a) begin
        errors++; $display("FAIL vds_busy cyc=%0d got rdy=%b hold_ok=%b exp 0/1", cyc, msg_ready, (msg_hold === a)); end
      seen = done;
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL vds_done_timeout got=0 exp=1"); end
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL vds_ready_after got=%b exp=1", msg_ready); end
    tick();
    msg_valid = 1'b0;
    checks++; if (msg_hold !== b || chunk_valid !== 1'b1 || chunk_idx !== 2'd0) begin
      errors++; $display("FAIL vds_second got hold_ok=%b v=%b idx=%0d exp 1/1/0", (msg_hold === b), chunk_valid, chunk_idx); end
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin seen = done; tick(); end
    checks++; if (!seen) begin errors++; $display("FAIL vds_drain_timeout got=0 exp=1"); end
    enc_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [TK-1:0] m, m2;
    int n, done_cyc;
    bit hit;
    m = tagged_msg(); m2 = rand_msg();
    msg_in = m; msg_valid = 1'b1; enc_ready = 1'b1;
    tick();
    msg_valid = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      if (chunk_valid && chunk_idx == 2'd2) hit = 1'b1;
      else tick();
    end
    checks++; if (!hit) begin errors++; $display("FAIL flush_reach_chunk2 got=0 exp=1"); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (msg_ready !== 1'b1 || sm !== 1'b0 || sel !== 2'd0 || chunk_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_idle got rdy=%b sm=%b sel=%0d v=%b done=%b exp 1/0/0/0/0", msg_ready, sm, sel, chunk_valid, done); end
    checks++; if (msg_hold !== m) begin errors++; $display("FAIL flush_hold_kept got=%0h", msg_hold[TCW-1:0]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (done !== 1'b0 || msg_ready !== 1'b1) begin
        errors++; $display("FAIL flush_no_done i=%0d got done=%b rdy=%b exp 0/1", i, done, msg_ready); end
    end
    // Flush in IDLE must not block a new message.
    msg_in = m2; msg_valid = 1'b1; flush = 1'b1;
    tick();
    msg_valid = 1'b0; flush = 1'b0;
    n = 0; done_cyc = -1;
    for (int cyc = 1; cyc < 12 && done_cyc < 0; cyc++) begin
      if (chunk_valid && enc_ready) begin
        checks++; if (mux_out(msg_hold, sel) !== m2[n*TCW +: TCW] || chunk_idx !== 2'(n)) begin
          errors++; $display("FAIL flush_new_chunk n=%0d got idx=%0d data=%0h", n, chunk_idx, mux_out(msg_hold, sel)); end
        n++;
      end
      if (done) done_cyc = cyc;
      tick();
    end
    checks++; if (n !== 4 || done_cyc !== 5) begin
      errors++; $display("FAIL flush_new_msg got chunks=%0d done_cyc=%0d exp 4/5", n, done_cyc); end
    enc_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit hit;
    msg_in = rand_msg(); msg_valid = 1'b1; enc_ready = 1'b1;
    tick();
    msg_valid = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      if (chunk_valid && chunk_idx == 2'd2) hit = 1'b1;
      else tick();
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got=0 exp=1"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (msg_hold !== '0 || sm !== 1'b0 || sel !== 2'd0) begin
      errors++; $display("FAIL rstmid_regs got hold_zero=%b sm=%b sel=%0d exp 1/0/0", (msg_hold === '0), sm, sel); end
    checks++; if (chunk_valid !== 1'b0 || chunk_idx !== 2'd0 || chunk_last !== 1'b0 || done !== 1'b0 || msg_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_outs got v=%b idx=%0d last=%b done=%b rdy=%b exp 0/0/0/0/1",
                         chunk_valid, chunk_idx, chunk_last, done, msg_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b exp=0", done); end
    enc_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [TK-1:0] m1, m2;
    logic [TCW-1:0] expq[$];
    int acc, dones, n;
    int acc_cyc[2];
    bit accepted;
    m1 = rand_msg(); m2 = rand_msg();
    for (int k = 0; k < 4; k++) expq.push_back(m1[k*TCW +: TCW]);
    for (int k = 0; k < 4; k++) expq.push_back(m2[k*TCW +: TCW]);
    msg_in = m1; msg_valid = 1'b1; enc_ready = 1'b1;
    acc = 0; dones = 0; n = 0; acc_cyc[0] = -1; acc_cyc[1] = -1;
    for (int cyc = 0; cyc < 20 && dones < 2; cyc++) begin
      accepted = msg_valid && msg_ready;
      if (accepted && acc < 2) acc_cyc[acc] = cyc;
      if (accepted) acc++;
      if (chunk_valid && enc_ready) begin
        checks++; if (n >= 8 || mux_out(msg_hold, sel) !== expq[n]) begin
          errors++; $display("FAIL b2b_chunk n=%0d got=%0h", n, mux_out(msg_hold, sel)); end
        n++;
      end
      if (done) dones++;
      tick();
      if (acc == 1) msg_in = m2;
      if (acc >= 2) msg_valid = 1'b0;
    end
    checks++; if (acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 6) begin
      errors++; $display("FAIL b2b_spacing got acc=%0d gap=%0d exp 2/6", acc, acc_cyc[1] - acc_cyc[0]); end
    checks++; if (n !== 8 || dones !== 2) begin
      errors++; $display("FAIL b2b_counts got chunks=%0d dones=%0d exp 8/2", n, dones); end
    msg_valid = 1'b0; enc_ready = 1'b0;
  endtask

  // Reference model tracks messages and how many of their chunks remain.
  task automatic test_random();
    logic [TK-1:0] exp_msg;
    bit exp_active, exp_done;
    int exp_next;
    rst = 1'b1; msg_valid = 1'b0; flush = 1'b0; enc_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_msg = '0; exp_active = 1'b0; exp_done = 1'b0; exp_next = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (chunk_valid !== exp_active || sm !== exp_active) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got v=%b sm=%b exp=%b", cyc, chunk_valid, sm, exp_active); end
      checks++; if (msg_ready !== (!exp_active && !exp_done) || done !== exp_done) begin
        errors++; $display("FAIL rnd_rdy_done cyc=%0d got rdy=%b done=%b exp %b/%b", cyc, msg_ready, done,
                           (!exp_active && !exp_done), exp_done); end
      checks++; if (msg_hold !== exp_msg) begin
        errors++; $display("FAIL rnd_hold cyc=%0d got=%0h exp=%0h", cyc, msg_hold[TCW-1:0], exp_msg[TCW-1:0]); end
      if (exp_active) begin
        checks++; if (chunk_idx !== 2'(exp_next) || chunk_last !== (exp_next == 3) ||
                      mux_out(msg_hold, sel) !== exp_msg[exp_next*TCW +: TCW]) begin
          errors++; $display("FAIL rnd_chunk cyc=%0d got idx=%0d last=%b sel=%0d exp idx=%0d", cyc, chunk_idx,
                             chunk_last, sel, exp_next); end
      end else begin
        checks++; if (sel !== 2'd0 || chunk_idx !== 2'd0 || chunk_last !== 1'b0) begin
          errors++; $display("FAIL rnd_idle_outs cyc=%0d got sel=%0d idx=%0d last=%b exp 0/0/0", cyc, sel, chunk_idx, chunk_last); end
      end
      msg_valid = 1'($urandom_range(0, 1));
      msg_in    = rand_msg();
      enc_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      if (rst) begin
        exp_msg = '0; exp_active = 1'b0; exp_done = 1'b0; exp_next = 0;
      end else if (flush && (exp_active || exp_done)) begin
        exp_active = 1'b0; exp_done = 1'b0;
      end else if (exp_active) begin
        if (enc_ready) begin
          if (exp_next == 3) begin exp_active = 1'b0; exp_done = 1'b1; end
          else exp_next++;
        end
      end else if (exp_done) begin
        exp_done = 1'b0;
      end else if (msg_valid) begin
        exp_msg = msg_in; exp_active = 1'b1; exp_next = 0;
      end
      tick();
    end
    rst = 1'b0; msg_valid = 1'b0; flush = 1'b0; enc_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; msg_in = '0; msg_valid = 1'b0; enc_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_valid_during_send();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
